// File: rtl/raster_dispatch_pkg.sv
// Shared definitions for the rasterizer front-end dispatcher: record layout,
// counter widths, FSM encoding and a saturating increment helper.
package raster_pkg;

  // Triangle record: nine 16-bit fields, x1 in the most significant slot.
  localparam int TRI_BITS  = 144;
  localparam int FIELD_W   = 16;
  localparam int X1_OFF    = 128;
  localparam int Y1_OFF    = 112;
  localparam int C1_OFF    = 96;
  localparam int X2_OFF    = 80;
  localparam int Y2_OFF    = 64;
  localparam int C2_OFF    = 48;
  localparam int X3_OFF    = 32;
  localparam int Y3_OFF    = 16;
  localparam int C3_OFF    = 0;

  // Pixel count holds up to 320*240 with headroom; bit counter covers 0..143.
  localparam int PIX_W     = 17;
  localparam int CNT_W     = 8;
  localparam int ID_W      = 3;
  localparam int TRI_CNT_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_SHIFT     = 2'd1,
    ST_WAIT_DONE = 2'd2
  } state_e;

  // Increment by one when inc is set, holding at the all-ones ceiling.
  function automatic logic [PIX_W-1:0] sat_inc(input logic [PIX_W-1:0] v,
                                               input logic             inc);
    logic [PIX_W-1:0] r;
    if (inc && (v != {PIX_W{1'b1}})) begin
      r = v + {{(PIX_W-1){1'b0}}, 1'b1};
    end else begin
      r = v;
    end
    return r;
  endfunction

endpackage

// File: rtl/raster_dispatch_rr_arbiter.sv
// Combinational round-robin arbiter: the search starts just above the last
// winner (ptr_i) and wraps, so every requester is reached within N_REQ grants.
module rr_arbiter
  import raster_pkg::*;
#(
  parameter int N_REQ = 2
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [ID_W-1:0]  ptr_i,
  output logic [N_REQ-1:0] grant_o,
  output logic [ID_W-1:0]  idx_o,
  output logic             valid_o
);

  // Walk the requesters in priority order and keep only the first hit.
  always_comb begin : arb_search
    int   cand;
    logic hit;
    grant_o = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    cand    = 0;
    hit     = 1'b0;
    for (int off = 1; off <= N_REQ; off++) begin
      cand           = (int'(ptr_i) + off) % N_REQ;
      hit            = !valid_o && req_i[cand];
      grant_o[cand]  = hit;
      idx_o          = hit ? ID_W'(cand) : idx_o;
      valid_o        = valid_o | hit;
    end
  end

endmodule

// File: rtl/raster_dispatch.sv
// Rasterizer front-end: picks one producer's triangle record round-robin,
// serializes it MSB first on START/D, then waits for DONE while counting
// VALID pixels, with a timeout abort for a hung rasterizer.
module raster_dispatch
  import raster_pkg::*;
#(
  parameter int N_REQ   = 2,
  parameter int TO_W    = 22,
  parameter int TIMEOUT = 2097152
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [N_REQ-1:0]          REQ,
  input  logic [N_REQ*TRI_BITS-1:0] TRI,
  output logic [N_REQ-1:0]          ACK,
  output logic                      START,
  output logic                      D,
  input  logic                      R_VALID,
  input  logic                      R_DONE,
  output logic                      BUSY,
  output logic [ID_W-1:0]           GRANT_ID,
  output logic [PIX_W-1:0]          PIX_COUNT,
  output logic [TRI_CNT_W-1:0]      TRI_COUNT,
  output logic                      TO_ERR
);

  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT - 1);
  localparam logic [ID_W-1:0]  PTR_INIT = ID_W'(N_REQ - 1);
  localparam logic [CNT_W-1:0] BIT_TOP  = CNT_W'(TRI_BITS - 1);

  state_e                state_q, state_d;
  logic [N_REQ-1:0]      ack_q, ack_d;
  logic                  start_q, start_d;
  logic                  d_q, d_d;
  logic                  busy_q, busy_d;
  logic                  to_err_q, to_err_d;
  logic [ID_W-1:0]       grant_id_q, grant_id_d;
  logic [ID_W-1:0]       ptr_q, ptr_d;
  logic [PIX_W-1:0]      pix_q, pix_d;
  logic [PIX_W-1:0]      acc_q, acc_d;
  logic [TRI_CNT_W-1:0]  tri_cnt_q, tri_cnt_d;
  logic [TRI_BITS-1:0]   sh_q, sh_d;
  logic [CNT_W-1:0]      bit_q, bit_d;
  logic [TO_W-1:0]       to_q, to_d;

  logic [N_REQ-1:0]      arb_grant;
  logic [ID_W-1:0]       arb_idx;
  logic                  arb_valid;
  logic [TRI_BITS-1:0]   sel_rec;
  logic [PIX_W-1:0]      acc_inc;

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .req_i   (REQ),
    .ptr_i   (ptr_q),
    .grant_o (arb_grant),
    .idx_o   (arb_idx),
    .valid_o (arb_valid)
  );

  // One-hot grant selects the winning producer's record.
  always_comb begin
    sel_rec = '0;
    for (int i = 0; i < N_REQ; i++) begin
      sel_rec = sel_rec | (TRI[i*TRI_BITS +: TRI_BITS] & {TRI_BITS{arb_grant[i]}});
    end
  end

  // Next-state and registered-output computation for the dispatch FSM.
  always_comb begin
    state_d    = state_q;
    ack_d      = '0;
    start_d    = start_q;
    d_d        = d_q;
    to_err_d   = 1'b0;
    grant_id_d = grant_id_q;
    ptr_d      = ptr_q;
    pix_d      = pix_q;
    acc_d      = acc_q;
    tri_cnt_d  = tri_cnt_q;
    sh_d       = sh_q;
    bit_d      = bit_q;
    to_d       = to_q;
    acc_inc    = sat_inc(acc_q, R_VALID);

    case (state_q)
      ST_IDLE: begin
        if (arb_valid) begin
          ack_d      = arb_grant;
          sh_d       = sel_rec;
          grant_id_d = arb_idx;
          ptr_d      = arb_idx;
          start_d    = 1'b1;
          d_d        = sel_rec[TRI_BITS-1];
          bit_d      = BIT_TOP;
          state_d    = ST_SHIFT;
        end else begin
          start_d = 1'b0;
          d_d     = 1'b0;
        end
      end
      ST_SHIFT: begin
        // Rasterizer strobes are meaningless while the record is in flight.
        if (bit_q == {CNT_W{1'b0}}) begin
          start_d = 1'b0;
          d_d     = 1'b0;
          acc_d   = '0;
          to_d    = '0;
          state_d = ST_WAIT_DONE;
        end else begin
          sh_d  = {sh_q[TRI_BITS-2:0], 1'b0};
          d_d   = sh_q[TRI_BITS-2];
          bit_d = bit_q - {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      ST_WAIT_DONE: begin
        // DONE wins over a timeout expiring in the same cycle.
        if (R_DONE) begin
          pix_d     = acc_inc;
          tri_cnt_d = tri_cnt_q + {{(TRI_CNT_W-1){1'b0}}, 1'b1};
          state_d   = ST_IDLE;
        end else if (to_q == TO_LAST) begin
          to_err_d = 1'b1;
          state_d  = ST_IDLE;
        end else begin
          acc_d = acc_inc;
          to_d  = to_q + {{(TO_W-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        start_d = 1'b0;
        d_d     = 1'b0;
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers with synchronous reset taking priority.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= ST_IDLE;
      ack_q      <= '0;
      start_q    <= 1'b0;
      d_q        <= 1'b0;
      busy_q     <= 1'b0;
      to_err_q   <= 1'b0;
      grant_id_q <= '0;
      ptr_q      <= PTR_INIT;
      pix_q      <= '0;
      acc_q      <= '0;
      tri_cnt_q  <= '0;
      sh_q       <= '0;
      bit_q      <= '0;
      to_q       <= '0;
    end else begin
      state_q    <= state_d;
      ack_q      <= ack_d;
      start_q    <= start_d;
      d_q        <= d_d;
      busy_q     <= busy_d;
      to_err_q   <= to_err_d;
      grant_id_q <= grant_id_d;
      ptr_q      <= ptr_d;
      pix_q      <= pix_d;
      acc_q      <= acc_d;
      tri_cnt_q  <= tri_cnt_d;
      sh_q       <= sh_d;
      bit_q      <= bit_d;
      to_q       <= to_d;
    end
  end

  assign ACK       = ack_q;
  assign START     = start_q;
  assign D         = d_q;
  assign BUSY      = busy_q;
  assign TO_ERR    = to_err_q;
  assign GRANT_ID  = grant_id_q;
  assign PIX_COUNT = pix_q;
  assign TRI_COUNT = tri_cnt_q;

endmodule

// File: tb/tb_raster_dispatch.sv
// Directed bench for raster_dispatch: a table of full dispatch/complete
// transactions plus hand-written timeout, collision and mid-shift reset cases.
module tb_raster_dispatch;

  localparam int N = 2;
  localparam logic [143:0] REC0 = 144'h0040_0040_F801_0200_0040_07C1_0040_0200_003F;
  localparam logic [143:0] REC1 = 144'h1234_5678_9ABC_DEF0_0F0F_F0F0_A5A5_5A5A_C3C3;

  logic           CLK = 1'b0;
  logic           RST;
  logic [N-1:0]   REQ;
  logic [N*144-1:0] TRI;
  logic [N-1:0]   ACK;
  logic           START, D, R_VALID, R_DONE, BUSY, TO_ERR;
  logic [2:0]     GRANT_ID;
  logic [16:0]    PIX_COUNT;
  logic [15:0]    TRI_COUNT;

  int checks = 0;
  int errors = 0;
  int exp_tri = 0;
  int exp_pix = 0;

  raster_dispatch #(.N_REQ(N), .TO_W(22), .TIMEOUT(50)) dut (
    .CLK(CLK), .RST(RST), .REQ(REQ), .TRI(TRI), .ACK(ACK), .START(START),
    .D(D), .R_VALID(R_VALID), .R_DONE(R_DONE), .BUSY(BUSY),
    .GRANT_ID(GRANT_ID), .PIX_COUNT(PIX_COUNT), .TRI_COUNT(TRI_COUNT),
    .TO_ERR(TO_ERR)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [1:0] req;
    int         win;
    int         pre;
    int         nv;
    bit         dv;
    bit         noise;
    int         pix;
  } vec_t;

  vec_t tab [6];

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input bit ok, input string nm, input logic [143:0] act,
                     input logic [143:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Grant a record and collect the serial stream; returns just after the
  // edge that leaves SHIFT.
  task automatic dispatch(input logic [1:0] req, input int win,
                          input logic [143:0] rec, input bit noise);
    logic [143:0] got;
    logic [1:0]   oh;
    int           start_cnt;
    oh = 2'b00;
    oh[win] = 1'b1;
    REQ = req;
    tick();
    chk(ACK == oh, "ack_grant", 144'(ACK), 144'(oh));
    chk(GRANT_ID == 3'(win), "grant_id", 144'(GRANT_ID), 144'(win));
    chk(BUSY == 1'b1 && START == 1'b1, "busy_start", 144'({BUSY, START}), 144'(2'b11));
    got = '0;
    got[143] = D;
    start_cnt = START ? 1 : 0;
    R_VALID = noise;
    R_DONE  = noise;
    for (int i = 142; i >= 0; i--) begin
      tick();
      if (i == 142) chk(ACK == 2'b00, "ack_one_cycle", 144'(ACK), 144'(0));
      got[i] = D;
      if (START) start_cnt++;
    end
    R_VALID = 1'b0;
    R_DONE  = 1'b0;
    tick();
    chk(START == 1'b0 && D == 1'b0, "start_drop", 144'({START, D}), 144'(0));
    chk(start_cnt == 144, "start_len", 144'(start_cnt), 144'(144));
    chk(got == rec, "d_stream", got, rec);
    chk(BUSY == 1'b1, "busy_wait", 144'(BUSY), 144'(1));
  endtask

  // Wait pre idle cycles, nv VALID cycles, then DONE (with VALID=dv).
  task automatic complete(input int pre, input int nv, input bit dv, input int pix);
    for (int i = 0; i < pre; i++) tick();
    R_VALID = 1'b1;
    for (int i = 0; i < nv; i++) tick();
    R_VALID = dv;
    R_DONE  = 1'b1;
    tick();
    R_VALID = 1'b0;
    R_DONE  = 1'b0;
    exp_tri++;
    exp_pix = pix;
    chk(PIX_COUNT == 17'(pix), "pix_count", 144'(PIX_COUNT), 144'(pix));
    chk(TRI_COUNT == 16'(exp_tri), "tri_count", 144'(TRI_COUNT), 144'(exp_tri));
    chk(BUSY == 1'b0 && TO_ERR == 1'b0 && ACK == 2'b00, "done_idle",
        144'({BUSY, TO_ERR, ACK}), 144'(0));
  endtask

  initial begin
    int early;
    tab[0] = '{req: 2'b01, win: 0, pre: 0, nv: 36, dv: 1'b1, noise: 1'b0, pix: 37};
    tab[1] = '{req: 2'b11, win: 1, pre: 0, nv: 10, dv: 1'b0, noise: 1'b0, pix: 10};
    tab[2] = '{req: 2'b11, win: 0, pre: 0, nv: 10, dv: 1'b0, noise: 1'b0, pix: 10};
    tab[3] = '{req: 2'b11, win: 1, pre: 0, nv: 10, dv: 1'b0, noise: 1'b0, pix: 10};
    tab[4] = '{req: 2'b10, win: 1, pre: 2, nv: 0,  dv: 1'b1, noise: 1'b1, pix: 1};
    tab[5] = '{req: 2'b01, win: 0, pre: 5, nv: 3,  dv: 1'b0, noise: 1'b0, pix: 3};

    RST = 1'b1; REQ = '0; R_VALID = 1'b0; R_DONE = 1'b0;
    TRI = {REC1, REC0};
    tick(); tick();
    RST = 1'b0;
    chk({ACK, START, D, BUSY, TO_ERR} == 6'b0, "reset_ctl", 144'({ACK, START, D, BUSY, TO_ERR}), 144'(0));
    chk(GRANT_ID == 3'd0 && PIX_COUNT == 17'd0 && TRI_COUNT == 16'd0, "reset_cnt",
        144'({GRANT_ID, PIX_COUNT, TRI_COUNT}), 144'(0));

    for (int v = 0; v < 6; v++) begin
      dispatch(tab[v].req, tab[v].win, (tab[v].win == 1) ? REC1 : REC0, tab[v].noise);
      complete(tab[v].pre, tab[v].nv, tab[v].dv, tab[v].pix);
    end

    // Timeout with VALID traffic but no DONE: counters must stay put.
    dispatch(2'b10, 1, REC1, 1'b0);
    REQ = '0;
    R_VALID = 1'b1;
    early = 0;
    for (int i = 0; i < 49; i++) begin
      tick();
      if (TO_ERR) early++;
    end
    chk(early == 0, "to_early", 144'(early), 144'(0));
    tick();
    chk(TO_ERR == 1'b1 && BUSY == 1'b0, "to_pulse", 144'({TO_ERR, BUSY}), 144'(2'b10));
    chk(PIX_COUNT == 17'(exp_pix) && TRI_COUNT == 16'(exp_tri), "to_counts",
        144'({PIX_COUNT, TRI_COUNT}), 144'({17'(exp_pix), 16'(exp_tri)}));
    R_VALID = 1'b0;
    tick();
    chk(TO_ERR == 1'b0, "to_one_cycle", 144'(TO_ERR), 144'(0));
    dispatch(2'b01, 0, REC0, 1'b0);
    complete(0, 4, 1'b0, 4);

    // DONE on the exact cycle the timeout would fire.
    dispatch(2'b11, 1, REC1, 1'b0);
    REQ = '0;
    complete(0, 49, 1'b1, 50);
    tick();
    chk(TO_ERR == 1'b0, "collide_no_to", 144'(TO_ERR), 144'(0));

    // Reset while bit 70 is on D.
    dispatch_partial: begin
      REQ = 2'b01;
      tick();
      REQ = '0;
      for (int i = 0; i < 73; i++) tick();
      chk(START == 1'b1 && D == REC0[70], "mid_shift_bit70", 144'({START, D}), 144'({1'b1, REC0[70]}));
      RST = 1'b1;
      tick();
      RST = 1'b0;
      chk({ACK, START, D, BUSY, TO_ERR} == 6'b0, "rst_mid_ctl", 144'({ACK, START, D, BUSY, TO_ERR}), 144'(0));
      chk(GRANT_ID == 3'd0 && PIX_COUNT == 17'd0 && TRI_COUNT == 16'd0, "rst_mid_cnt",
          144'({GRANT_ID, PIX_COUNT, TRI_COUNT}), 144'(0));
    end
    exp_tri = 0;
    dispatch(2'b11, 0, REC0, 1'b0);
    complete(0, 0, 1'b1, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/raster_dispatch.md
Name: raster_dispatch

Overview:
- Front-end scheduler for the triangle rasterizer.
- Accepts complete 144-bit triangle records from N_REQ parallel producers and picks one with round-robin arbitration.
- Serializes the chosen record onto the rasterizer's START/D input, then waits for the rasterizer's DONE pulse before dispatching again.
- Counts VALID pixels per triangle, counts completed triangles, and flags a hung rasterizer with a timeout.

Parameters:
- N_REQ, 2, number of triangle producers (1..8).
- TRI_BITS, 144, record width: x1,y1,c1,x2,y2,c2,x3,y3,c3, each 16 bits; coordinates are Q10.6.
- TO_W, 22, timeout counter width.
- TIMEOUT, 2097152, maximum cycles allowed in WAIT_DONE before abort.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  synchronous, active-high reset.
- REQ  in  N_REQ  per-producer request; held high until ACK.
- TRI  in  N_REQ*TRI_BITS  records; producer i uses bits [i*144 +: 144], x1 in the top 16 bits.
- ACK  out  N_REQ  one-cycle grant/consume pulse, one-hot.
- START  out  1  to rasterizer: serial-data-valid.
- D  out  1  to rasterizer: serial data, MSB first.
- R_VALID  in  1  rasterizer VALID (pixel emitted).
- R_DONE  in  1  rasterizer DONE (triangle finished).
- BUSY  out  1  high in any state other than IDLE.
- GRANT_ID  out  3  index of the producer currently being served.
- PIX_COUNT  out  17  VALID pulses counted for the last finished triangle (maximum 320*240).
- TRI_COUNT  out  16  number of completed triangles, wraps modulo 2^16.
- TO_ERR  out  1  one-cycle pulse when a timeout abort occurs.

Behaviour:
- Reset: state=IDLE; ACK, START, D, BUSY, TO_ERR = 0; GRANT_ID, PIX_COUNT, TRI_COUNT = 0; round-robin pointer = N_REQ-1, so producer 0 has first priority. Reset wins over every other event, including mid-SHIFT: START drops at the reset edge and the partial record is discarded.
- States: IDLE, SHIFT, WAIT_DONE.
- IDLE, at an edge where any REQ is high:
  - Winner = first set REQ searching upward from pointer+1, wrapping.
  - Registered outputs at that edge: ACK[winner]=1 for exactly one cycle; the winner's record loads into the shift register; GRANT_ID=winner; pointer=winner; START=1; D=record[143]; bit counter=143; state=SHIFT.
- SHIFT:
  - Each edge shifts left by one; D presents the next bit; the counter decrements.
  - START is high for exactly 144 consecutive cycles.
  - On the edge where the counter is 0: START=0, D=0, state=WAIT_DONE, pixel accumulator=0, timeout counter=0.
  - R_VALID and R_DONE are ignored in SHIFT.
- WAIT_DONE:
  - Each R_VALID=1 cycle increments the accumulator, saturating at 2^17-1.
  - The timeout counter increments each cycle.
  - If R_DONE=1: PIX_COUNT = accumulator, plus 1 if R_VALID is also high that cycle; TRI_COUNT+1; state=IDLE.
  - Else if the timeout counter == TIMEOUT-1: TO_ERR=1 for one cycle; PIX_COUNT and TRI_COUNT unchanged; state=IDLE.
  - R_DONE has priority over timeout on the same cycle.
- Minimum dispatch-to-dispatch gap: one IDLE cycle, so a new grant cannot occur on the R_DONE edge itself.
- A REQ dropped before ACK is simply not served. REQs arriving outside IDLE wait.
- The arbiter is fair: with all requesters continuously active, grants rotate 0,1,..,N_REQ-1,0.
- BUSY is a registered output equal to (next state != IDLE).

Decomposition:
- Shared package raster_pkg: TRI_BITS, the field offsets of the 16-bit record fields, pixel-count width 17, and the state encoding.
- One sub-module, rr_arbiter (N_REQ, REQ, pointer -> one-hot grant plus index), is combinational and reusable by future pixel-output arbitration.

Test Plan:
- Single dispatch: REQ=01, TRI[143:0]=0x0040_0040_F801_0200_0040_07C1_0040_0200_003F -> ACK[0] pulses one cycle; START high for 144 cycles; D sequence equals the record MSB-first; BUSY=1.
- Completion: in WAIT_DONE, drive R_VALID for 37 cycles (the last one coincident with R_DONE) -> PIX_COUNT=37, TRI_COUNT=1, state IDLE one cycle later.
- Round-robin: REQ=11 held continuously, DONE returned 10 cycles after each shift -> grant order 0,1,0,1; GRANT_ID matches; ACKs are never simultaneous.
- Timeout: TIMEOUT=50, never assert R_DONE -> TO_ERR pulses exactly 50 cycles after entering WAIT_DONE; TRI_COUNT unchanged; next REQ is served.
- Reset mid-shift: assert RST at bit 70 -> START=0 and all outputs at reset values after that edge; next REQ restarts a full 144-bit shift from bit 143.
- Collision: R_DONE and timeout expiry in the same cycle -> completion counted, TO_ERR stays 0.
